// File: rtl/csr_tohost_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : csr_tohost_unit                                                  |
// | Brief   : CSRRW/RS/RC execution, tohost completion latch, cycle/instret.   |
// |           Optional branch statistics CSRs enabled by CSR_BRANCH_STATS_EN.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module csr_tohost_unit #(
    parameter logic [11:0] TOHOST_ADDR = 12'h51E,
    parameter int unsigned COUNTER_W   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instr_retire,
`ifdef CSR_BRANCH_STATS_EN
    input  logic        br_resolve,
    input  logic        br_mispredict,
`endif
    output logic [31:0] tohost,
    output logic        test_done,
    output logic        test_pass,
    output logic [30:0] fail_id
);
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
    localparam logic [11:0] ADDR_BR_RES   = 12'h7C0;
    localparam logic [11:0] ADDR_BR_MIS   = 12'h7C1;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic [COUNTER_W-1:0] cycle_q, cycle_d;
    logic [COUNTER_W-1:0] instret_q, instret_d;
    logic [31:0]          tohost_q, tohost_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [30:0]          fail_q, fail_d;

    logic [63:0] cycle_ext;
    logic [63:0] instret_ext;
    logic        addr_ok;
    logic        wr_en;
    logic [31:0] wr_val;

`ifdef CSR_BRANCH_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;
`endif

    // High halves read as zero-extended slices of the counters.
    assign cycle_ext   = 64'(cycle_q);
    assign instret_ext = 64'(instret_q);

    always_comb begin
        csr_rdata = 32'h0;
        addr_ok   = 1'b1;
        case (csr_addr)
            TOHOST_ADDR:   csr_rdata = tohost_q;
            ADDR_CYCLE:    csr_rdata = cycle_ext[31:0];
            ADDR_CYCLEH:   csr_rdata = cycle_ext[63:32];
            ADDR_INSTRET:  csr_rdata = instret_ext[31:0];
            ADDR_INSTRETH: csr_rdata = instret_ext[63:32];
`ifdef CSR_BRANCH_STATS_EN
            ADDR_BR_RES:   csr_rdata = br_cnt_q;
            ADDR_BR_MIS:   csr_rdata = mis_cnt_q;
`endif
            default:       addr_ok   = 1'b0;
        endcase
    end

    assign csr_illegal = csr_en && !addr_ok;
    assign wr_en       = csr_en && !stall && (csr_op != OP_NONE) && (csr_addr == TOHOST_ADDR);

    always_comb begin
        case (csr_op)
            OP_RS:   wr_val = tohost_q | csr_wdata;
            OP_RC:   wr_val = tohost_q & ~csr_wdata;
            default: wr_val = csr_wdata;
        endcase
    end

    always_comb begin
        cycle_d   = cycle_q + COUNTER_W'(1);
        instret_d = instret_q;
        tohost_d  = tohost_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        if (instr_retire && !stall) begin
            instret_d = instret_q + COUNTER_W'(1);
        end
        if (wr_en) begin
            tohost_d = wr_val;
            // Only the first completing write latches status; later ones just update tohost.
            if (wr_val[0] && !done_q) begin
                done_d = 1'b1;
                pass_d = (wr_val[31:1] == 31'd0);
                fail_d = wr_val[31:1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
            tohost_q  <= 32'h0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 31'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            tohost_q  <= tohost_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

`ifdef CSR_BRANCH_STATS_EN
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (br_resolve && !stall) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (br_mispredict) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q  <= 32'h0;
            mis_cnt_q <= 32'h0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end
`endif

    assign tohost    = tohost_q;
    assign test_done = done_q;
    assign test_pass = pass_q;
    assign fail_id   = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_tohost_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_csr_tohost_unit                                               |
// | Brief   : Directed and randomized checks of csr_tohost_unit against a      |
// |           behavioural model; honours CSR_BRANCH_STATS_EN when defined.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_csr_tohost_unit;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire;
    logic [31:0] tohost;
    logic        test_done;
    logic        test_pass;
    logic [30:0] fail_id;
`ifdef CSR_BRANCH_STATS_EN
    logic        br_resolve;
    logic        br_mispredict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    csr_tohost_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .csr_en       (csr_en),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .instr_retire (instr_retire),
`ifdef CSR_BRANCH_STATS_EN
        .br_resolve   (br_resolve),
        .br_mispredict(br_mispredict),
`endif
        .tohost       (tohost),
        .test_done    (test_done),
        .test_pass    (test_pass),
        .fail_id      (fail_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic [31:0] m_tohost;
    logic        m_done;
    logic        m_pass;
    logic [30:0] m_fail;
    logic [31:0] m_br;
    logic [31:0] m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_legal(input logic [11:0] a);
        case (a)
            12'h51E, 12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
`ifdef CSR_BRANCH_STATS_EN
            12'h7C0, 12'h7C1: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h51E: return m_tohost;
            12'hC00: return m_cycle[31:0];
            12'hC80: return m_cycle[63:32];
            12'hC02: return m_instret[31:0];
            12'hC82: return m_instret[63:32];
`ifdef CSR_BRANCH_STATS_EN
            12'h7C0: return m_br;
            12'h7C1: return m_mis;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] new_tohost();
        case (csr_op)
            2'b01:   return csr_wdata;
            2'b10:   return m_tohost | csr_wdata;
            2'b11:   return m_tohost & ~csr_wdata;
            default: return m_tohost;
        endcase
    endfunction

    function automatic logic model_writes();
        return csr_en && !stall && (csr_op != 2'b00) && (csr_addr == 12'h51E);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cycle   <= 64'd0;
            m_instret <= 64'd0;
            m_tohost  <= 32'h0;
            m_done    <= 1'b0;
            m_pass    <= 1'b0;
            m_fail    <= 31'd0;
            m_br      <= 32'h0;
            m_mis     <= 32'h0;
        end else begin
            m_cycle <= m_cycle + 64'd1;
            if (instr_retire && !stall) m_instret <= m_instret + 64'd1;
`ifdef CSR_BRANCH_STATS_EN
            if (br_resolve && !stall) m_br <= m_br + 32'd1;
            if (br_resolve && br_mispredict && !stall) m_mis <= m_mis + 32'd1;
`endif
            if (model_writes()) begin
                m_tohost <= new_tohost();
                if (!m_done && (new_tohost() & 32'h1) != 32'h0) begin
                    m_done <= 1'b1;
                    m_pass <= (new_tohost() >> 1) == 32'h0;
                    m_fail <= 31'(new_tohost() >> 1);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("tohost", tohost, m_tohost);
            chk("test_done", 32'(test_done), 32'(m_done));
            if (m_done) begin
                chk("test_pass", 32'(test_pass), 32'(m_pass));
                chk("fail_id", 32'(fail_id), 32'(m_fail));
            end
            if (csr_en) begin
                chk("csr_rdata", csr_rdata, m_read(csr_addr));
                chk("csr_illegal", 32'(csr_illegal), 32'(!m_legal(csr_addr)));
            end else begin
                chk("csr_illegal_idle", 32'(csr_illegal), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
    endtask

    task automatic idle();
        csr_en    = 1'b0;
        csr_op    = 2'b00;
        csr_addr  = 12'h000;
        csr_wdata = 32'h0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] addrs [8];
        addrs = '{12'h51E, 12'h51E, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h7C1};
        rst = 1'b0;
        stall = 1'b0;
        instr_retire = 1'b0;
        idle();
`ifdef CSR_BRANCH_STATS_EN
        br_resolve = 1'b0;
        br_mispredict = 1'b0;
`endif
        #1 rst = 1'b1;

        // 1: reset, then cycle counter from the deassert edge
        repeat (30) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_tohost", tohost, 32'h0);
        chk("rst_done", 32'(test_done), 32'h0);
        chk("rst_pass", 32'(test_pass), 32'h0);
        chk("rst_fail_id", 32'(fail_id), 32'h0);
        repeat (10) @(posedge clk);
        #1;
        issue(2'b10, 12'hC00, 32'h0);
        #1;
        chk("cycle_after_10", csr_rdata, 32'd10);
        chk("model_cycle_10", m_cycle[31:0], 32'd10);
        csr_addr = 12'hC80;
        #1;
        chk("cycle_high_zero", csr_rdata, 32'h0);
        tick();

        // 2: passing completion
        issue(2'b01, 12'h51E, 32'h1);
        #1;
        chk("done_before_edge", 32'(test_done), 32'h0);
        tick();
        idle();
        chk("t2_tohost", tohost, 32'h1);
        chk("t2_done", 32'(test_done), 32'h1);
        chk("t2_pass", 32'(test_pass), 32'h1);
        chk("t2_fail_id", 32'(fail_id), 32'h0);

        // 3: failing completion, later writes leave flags frozen
        rst = 1'b1;
        #1;
        chk("async_clear_done", 32'(test_done), 32'h0);
        chk("async_clear_tohost", tohost, 32'h0);
        rst = 1'b0;
        tick();
        issue(2'b01, 12'h51E, 32'h0000_000B);
        tick();
        idle();
        chk("t3_done", 32'(test_done), 32'h1);
        chk("t3_pass", 32'(test_pass), 32'h0);
        chk("t3_fail_id", 32'(fail_id), 32'd5);
        chk("model_fail_id", 32'(m_fail), 32'd5);
        issue(2'b01, 12'h51E, 32'h1);
        tick();
        idle();
        chk("t3_tohost_late", tohost, 32'h1);
        chk("t3_pass_frozen", 32'(test_pass), 32'h0);
        chk("t3_fail_frozen", 32'(fail_id), 32'd5);

        // 4: RS then stalled RC
        pulse_reset();
        tick();
        issue(2'b10, 12'h51E, 32'h4);
        tick();
        chk("t4_tohost_rs", tohost, 32'h4);
        issue(2'b11, 12'h51E, 32'h4);
        stall = 1'b1;
        #1;
        chk("t4_rdata_stall", csr_rdata, 32'h4);
        tick();
        stall = 1'b0;
        idle();
        chk("t4_tohost_kept", tohost, 32'h4);
        chk("t4_not_done", 32'(test_done), 32'h0);

        // 5: retire counting with stalls, read-only counters, illegal address
        pulse_reset();
        tick();
        for (int i = 0; i < 7; i++) begin
            instr_retire = 1'b1;
            stall = (i == 2) || (i == 5);
            tick();
        end
        instr_retire = 1'b0;
        stall = 1'b0;
        issue(2'b10, 12'hC02, 32'h0);
        #1;
        chk("t5_instret", csr_rdata, 32'd5);
        issue(2'b01, 12'hC02, 32'hFFFF);
        #1;
        chk("t5_ro_legal", 32'(csr_illegal), 32'h0);
        tick();
        issue(2'b10, 12'hC02, 32'h0);
        #1;
        chk("t5_instret_kept", csr_rdata, 32'd5);
        issue(2'b10, 12'h123, 32'h0);
        #1;
        chk("t5_bad_rdata", csr_rdata, 32'h0);
        chk("t5_bad_illegal", 32'(csr_illegal), 32'h1);
        tick();

`ifdef CSR_BRANCH_STATS_EN
        // 6: branch statistics and asynchronous clear
        pulse_reset();
        idle();
        tick();
        for (int i = 0; i < 5; i++) begin
            br_resolve    = (i != 2);
            br_mispredict = (i == 1) || (i == 2);
            tick();
        end
        br_resolve = 1'b0;
        br_mispredict = 1'b0;
        issue(2'b10, 12'h7C0, 32'h0);
        #1;
        chk("t6_br_resolved", csr_rdata, 32'd4);
        csr_addr = 12'h7C1;
        #1;
        chk("t6_br_mispredict", csr_rdata, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_mis_async_clr", csr_rdata, 32'h0);
        csr_addr = 12'h7C0;
        #1;
        chk("t6_br_async_clr", csr_rdata, 32'h0);
        rst = 1'b0;
        tick();
`else
        issue(2'b10, 12'h7C0, 32'h0);
        #1;
        chk("nostats_illegal", 32'(csr_illegal), 32'h1);
        chk("nostats_rdata", csr_rdata, 32'h0);
        tick();
`endif

        // Randomized phase, model-checked every cycle
        for (int r = 0; r < 4; r++) begin
            idle();
            pulse_reset();
            tick();
            for (int c = 0; c < 250; c++) begin
                int unsigned sel;
                sel = $urandom % 9;
                csr_en = ($urandom % 4) != 0;
                csr_op = 2'($urandom);
                csr_addr = (sel == 8) ? 12'($urandom) : addrs[sel];
                case ($urandom % 8)
                    0:       csr_wdata = 32'h1;
                    1:       csr_wdata = $urandom | 32'h1;
                    2:       csr_wdata = 32'h0;
                    default: csr_wdata = $urandom & ~32'h1;
                endcase
                stall = ($urandom % 4) == 0;
                instr_retire = ($urandom % 2) != 0;
`ifdef CSR_BRANCH_STATS_EN
                br_resolve = ($urandom % 2) != 0;
                br_mispredict = ($urandom % 2) != 0;
`endif
                if (($urandom % 150) == 0) pulse_reset();
                tick();
            end
        end
        idle();
        stall = 1'b0;
        instr_retire = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
